// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: TX_status_register bit indices and the arbiter FSM state type.
package uart_pkg;

  // Bit positions inside uart_protocol TX_status_register.
  localparam int ST_EMPTY = 2;
  localparam int ST_FULL  = 1;
  localparam int ST_WERR  = 0;

  typedef enum logic [1:0] {ARB, XFER, SETTLE} arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin search over a request vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether to use the pick.
// Ports: req_i  - request vector
//        ptr_i  - index where the search starts (wraps modulo NUM_REQ)
//        pick_o - one-hot first request at or after ptr_i
//        found_o- at least one request was set
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               found_o
);

  localparam int SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] idx;

  always_comb begin
    pick_o  = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr_i < NUM_REQ, so a single subtraction is enough to wrap.
      idx = {1'b0, ptr_i} + SUM_W'(k);
      if (idx >= SUM_W'(NUM_REQ)) begin
        idx = idx - SUM_W'(NUM_REQ);
      end
      if (!found_o && req_i[idx[PTR_W-1:0]]) begin
        pick_o[idx[PTR_W-1:0]] = 1'b1;
        found_o                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_protocol TX port between NUM_REQ byte streams, round-robin with packet lock.
// Latency: 1 cycle search, 1 cycle handshake->write_data, 2 cycles last byte->next grant; max 1 byte per 2 cycles.
// Backpressure: req_ready drops while tx_status[1] (FIFO full) is high; the grant is held until the last byte.
// Ports: req_valid/req_last/req_data/req_ready - per-requester byte interface
//        tx_status - TX_status_register; write_data/bus_data_in - write port into uart_protocol
//        grant/busy - current owner and FSM activity; err_count - saturating write-error edge count
//        timeout - revocation pulse, only with UART_ARB_TIMEOUT_EN defined (tied 0 otherwise)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int ERR_CNT_W = 8,
  parameter int MAX_IDLE  = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [7:0]                     tx_status,
  output logic                           write_data,
  output logic [DATA_SIZE-1:0]           bus_data_in,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic [ERR_CNT_W-1:0]           err_count,
  output logic                           timeout
);

  localparam int              PTR_W    = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  arb_state_e            state_q;
  logic [NUM_REQ-1:0]    grant_q;
  logic [PTR_W-1:0]      owner_q;
  logic [PTR_W-1:0]      ptr_q;
  logic                  wr_q;
  logic                  last_q;
  logic                  werr_prev_q;
  logic [DATA_SIZE-1:0]  data_q;
  logic [ERR_CNT_W-1:0]  err_q;
  logic [ERR_CNT_W-1:0]  err_d;
  logic [PTR_W-1:0]      ptr_d;

  logic [NUM_REQ-1:0]    pick;
  logic                  found;
  logic [PTR_W-1:0]      pick_idx;
  logic                  own_vld;
  logic                  own_last;
  logic [DATA_SIZE-1:0]  own_dat;
  logic                  hs;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .found_o (found)
  );

  // One-hot to index, so the owner can be used to select its byte lane.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  assign own_vld  = req_valid[owner_q];
  assign own_last = req_last[owner_q];
  assign own_dat  = req_data[int'(owner_q) * DATA_SIZE +: DATA_SIZE];

  assign req_ready = (state_q == XFER && !tx_status[ST_FULL]) ? grant_q : '0;
  assign hs        = |(req_valid & req_ready);

  assign ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  // Count only 0->1 transitions of the write-error flag, sticking at all-ones.
  assign err_d = (tx_status[ST_WERR] && !werr_prev_q && (err_q != '1)) ? err_q + 1'b1 : err_q;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(MAX_IDLE + 1);
  logic [IDLE_W-1:0] idle_q;
  logic              timeout_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      grant_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      wr_q        <= 1'b0;
      last_q      <= 1'b0;
      werr_prev_q <= 1'b0;
      data_q      <= '0;
      err_q       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      idle_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      wr_q        <= 1'b0;
      werr_prev_q <= tx_status[ST_WERR];
      err_q       <= err_d;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state_q)
        ARB: begin
          if (found) begin
            grant_q <= pick;
            owner_q <= pick_idx;
            state_q <= XFER;
`ifdef UART_ARB_TIMEOUT_EN
            idle_q  <= '0;
`endif
          end else begin
            grant_q <= '0;
          end
        end
        XFER: begin
          if (hs) begin
            data_q  <= own_dat;
            wr_q    <= 1'b1;
            last_q  <= own_last;
            state_q <= SETTLE;
`ifdef UART_ARB_TIMEOUT_EN
            idle_q  <= '0;
`endif
          end
`ifdef UART_ARB_TIMEOUT_EN
          // Stalls on FIFO full keep valid high and therefore do not count.
          else if (!own_vld) begin
            if (idle_q == IDLE_W'(MAX_IDLE - 1)) begin
              timeout_q <= 1'b1;
              grant_q   <= '0;
              ptr_q     <= ptr_d;
              idle_q    <= '0;
              state_q   <= ARB;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
`endif
        end
        SETTLE: begin
          // uart_protocol samples the strobe now; full is trustworthy next cycle.
          if (last_q) begin
            ptr_q   <= ptr_d;
            grant_q <= '0;
            state_q <= ARB;
          end else begin
            state_q <= XFER;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign write_data  = wr_q;
  assign bus_data_in = data_q;
  assign grant       = grant_q;
  assign busy        = (state_q != ARB);
  assign err_count   = err_q;

  logic unused_status;
  assign unused_status = ^{tx_status[7:3], tx_status[ST_EMPTY], own_vld};

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
  logic unused_idle;
  assign unused_idle = (MAX_IDLE > 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter.
// Latency: n/a (drives inputs 1 time unit after posedge, samples registered outputs there or at negedge).
// Backpressure: FIFO full is driven randomly in the random phase and held in a directed stall.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int EW = 8;
  localparam int MI = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic [7:0]      tx_status;
  logic            write_data, busy, timeout;
  logic [DW-1:0]   bus_data_in;
  logic [EW-1:0]   err_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (N),
    .DATA_SIZE (DW),
    .ERR_CNT_W (EW),
    .MAX_IDLE  (MI)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_status   (tx_status),
    .write_data  (write_data),
    .bus_data_in (bus_data_in),
    .grant       (grant),
    .busy        (busy),
    .err_count   (err_count),
    .timeout     (timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_status = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_byte(input int i, input logic [7:0] b, input logic l);
    req_data[i*DW +: DW] = b;
    req_last[i]          = l;
  endtask

  // Send one single-byte packet from requester s so the pointer lands on s+1.
  task automatic setup_ptr(input int s);
    if (s >= 0) begin
      req_valid    = '0;
      req_valid[s] = 1'b1;
      set_byte(s, 8'h5A, 1'b1);
      step();
      step();
      req_valid = '0;
      step();
    end
  endtask

  typedef struct {
    int           setup;
    logic [N-1:0] vld;
    logic [N-1:0] exp_gnt;
  } vec_t;

  vec_t vecs[9];

  logic [7:0] rb [N][16];
  logic       rl [N][16];
  int         rlen [N];
  int         pos  [N];
  int         gap  [N];
  int         mp   [N];
  logic [7:0] exp_q [$];
  logic [N-1:0] got [4];

  int widx, cyc, found, mptr, np, len, nw, first_k;
  bit seen, is_first, done_pkt;
  logic [N-1:0] gnt_at_to;

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Reset values.
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_wr", 32'(write_data), 32'h0);
    check("rst_bus", 32'(bus_data_in), 32'h0);
    check("rst_err", 32'(err_count), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);

    // Arbitration table: pointer preset by a prior packet, then one search.
    vecs[0] = '{-1, 4'b0000, 4'b0000};
    vecs[1] = '{-1, 4'b0001, 4'b0001};
    vecs[2] = '{-1, 4'b1010, 4'b0010};
    vecs[3] = '{-1, 4'b1111, 4'b0001};
    vecs[4] = '{ 0, 4'b1111, 4'b0010};
    vecs[5] = '{ 1, 4'b0011, 4'b0001};
    vecs[6] = '{ 3, 4'b1001, 4'b0001};
    vecs[7] = '{ 2, 4'b1100, 4'b1000};
    vecs[8] = '{ 2, 4'b0100, 4'b0100};
    for (int v = 0; v < 9; v++) begin
      do_reset();
      setup_ptr(vecs[v].setup);
      req_valid = vecs[v].vld;
      req_last  = '1;
      step();
      check($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_gnt));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_gnt != '0));
      check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_gnt));
      tx_status[1] = 1'b1;
      #1;
      check($sformatf("vec%0d_ready_full", v), 32'(req_ready), 32'h0);
      check($sformatf("vec%0d_wr", v), 32'(write_data), 32'h0);
      tx_status[1] = 1'b0;
    end

    // Two-byte packet from requester 0.
    do_reset();
    req_valid = 4'b0001;
    set_byte(0, 8'hA5, 1'b0);
    step();
    check("p2_grant", 32'(grant), 32'h1);
    step();
    check("p2_wr0", 32'(write_data), 32'h1);
    check("p2_bus0", 32'(bus_data_in), 32'hA5);
    set_byte(0, 8'h3C, 1'b1);
    #1;
    check("p2_settle_ready", 32'(req_ready), 32'h0);
    step();
    check("p2_gap_wr", 32'(write_data), 32'h0);
    step();
    check("p2_wr1", 32'(write_data), 32'h1);
    check("p2_bus1", 32'(bus_data_in), 32'h3C);
    req_valid = '0;
    step();
    check("p2_grant_idle", 32'(grant), 32'h0);

    // Requesters 0 and 2 alternate.
    do_reset();
    req_valid = 4'b0101;
    req_last  = '1;
    set_byte(0, 8'h01, 1'b1);
    set_byte(2, 8'h03, 1'b1);
    nw = 0;
    for (int k = 0; k < 40 && nw < 4; k++) begin
      step();
      if (write_data) begin
        got[nw] = grant;
        nw++;
      end
    end
    check("alt_count", 32'(nw), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("alt_owner%0d", k), 32'(got[k]), (k % 2 == 0) ? 32'h1 : 32'h4);
    end

    // FIFO full stall mid-packet on requester 1.
    do_reset();
    req_valid = 4'b0010;
    set_byte(1, 8'h11, 1'b0);
    step();
    step();
    check("full_wr0", 32'(bus_data_in), 32'h11);
    set_byte(1, 8'h22, 1'b0);
    tx_status[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("full_ready", 32'(req_ready), 32'h0);
      check("full_wr", 32'(write_data), 32'h0);
      check("full_grant", 32'(grant), 32'h2);
    end
    tx_status[1] = 1'b0;
    #1;
    check("full_release_ready", 32'(req_ready), 32'h2);
    step();
    check("full_after_wr", 32'(write_data), 32'h1);
    check("full_after_bus", 32'(bus_data_in), 32'h22);
    check("full_after_grant", 32'(grant), 32'h2);

    // Write-error edge counter and saturation.
    do_reset();
    tx_status[0] = 1'b1;
    step(); step(); step();
    tx_status[0] = 1'b0;
    step();
    tx_status[0] = 1'b1;
    step();
    tx_status[0] = 1'b0;
    step();
    check("err_two", 32'(err_count), 32'd2);
    for (int k = 0; k < 300; k++) begin
      tx_status[0] = 1'b1;
      step();
      tx_status[0] = 1'b0;
      step();
    end
    check("err_sat", 32'(err_count), 32'd255);

    // Reset during SETTLE of a 4-byte packet.
    do_reset();
    req_valid = 4'b0100;
    set_byte(2, 8'hB0, 1'b0);
    step();
    step();
    set_byte(2, 8'hB1, 1'b0);
    step();
    step();
    check("rs_in_settle", 32'(write_data), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("rs_grant", 32'(grant), 32'h0);
    check("rs_wr", 32'(write_data), 32'h0);
    check("rs_bus", 32'(bus_data_in), 32'h0);
    check("rs_busy", 32'(busy), 32'h0);
    check("rs_ready", 32'(req_ready), 32'h0);
    step();
    reset = 1'b0;
    req_valid = 4'b1111;
    req_last  = '1;
    step();
    check("rs_next_grant", 32'(grant), 32'h1);

    // Owner drops valid mid-packet while requester 3 waits.
    do_reset();
    req_valid = 4'b0010;
    set_byte(1, 8'h55, 1'b0);
    set_byte(3, 8'h77, 1'b1);
    step();
    step();
    req_valid = 4'b1000;
    first_k = 0;
    seen = 1'b0;
    gnt_at_to = '0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step();
      if (timeout) begin
        seen      = 1'b1;
        first_k   = k;
        gnt_at_to = grant;
      end
    end
`ifdef UART_ARB_TIMEOUT_EN
    check("to_cycle", 32'(first_k), 32'd17);
    check("to_grant_clear", 32'(gnt_at_to), 32'h0);
    step();
    check("to_pulse_width", 32'(timeout), 32'h0);
    check("to_next_grant", 32'(grant), 32'h8);
`else
    check("to_never", 32'(seen), 32'h0);
    check("to_grant_held", 32'(grant), 32'h2);
    check("to_busy", 32'(busy), 32'h1);
`endif

    // Random packets against a packet-level round-robin model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        rlen[i] = 0;
        pos[i]  = 0;
        gap[i]  = 0;
        np = (i == r) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
        for (int p = 0; p < np; p++) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++) begin
            rb[i][rlen[i]] = 8'($urandom);
            rl[i][rlen[i]] = (b == len - 1);
            rlen[i]++;
          end
        end
      end
      // Expected write stream: whole packets, next owner is first non-empty at/after pointer.
      for (int i = 0; i < N; i++) mp[i] = 0;
      mptr = 0;
      found = 0;
      while (found >= 0) begin
        found = -1;
        for (int k = 0; k < N; k++) begin
          if (found < 0 && mp[(mptr + k) % N] < rlen[(mptr + k) % N]) found = (mptr + k) % N;
        end
        if (found >= 0) begin
          done_pkt = 1'b0;
          while (!done_pkt) begin
            exp_q.push_back(rb[found][mp[found]]);
            done_pkt = rl[found][mp[found]];
            mp[found]++;
          end
          mptr = (found + 1) % N;
        end
      end
      widx = 0;
      cyc  = 0;
      while (widx < exp_q.size() && cyc < 2000) begin
        for (int i = 0; i < N; i++) begin
          if (pos[i] < rlen[i]) begin
            is_first     = (pos[i] == 0) || rl[i][pos[i] - 1];
            req_valid[i] = is_first || (gap[i] == 0);
            set_byte(i, rb[i][pos[i]], rl[i][pos[i]]);
          end else begin
            req_valid[i] = 1'b0;
            set_byte(i, 8'h00, 1'b0);
          end
        end
        tx_status[1] = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        if (write_data) begin
          check($sformatf("rand%0d_byte%0d", r, widx), 32'(bus_data_in), 32'(exp_q[widx]));
          widx++;
        end
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            gap[i] = rl[i][pos[i]] ? 0 : int'($urandom_range(0, 2));
            pos[i]++;
          end else if (gap[i] > 0) begin
            gap[i]--;
          end
        end
        step();
        cyc++;
      end
      check($sformatf("rand%0d_count", r), 32'(widx), 32'(exp_q.size()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
